// File: rtl/lab61soc_switch_ctrl.sv
// -----------------------------------------------------------------------------
// lab61soc_switch_ctrl
//   Avalon-MM slave for eight slide switches.
//   Each switch bit is synchronized, debounced and recorded in an edge-capture
//   register that can raise a level interrupt.
//
//   Build option: SWITCH_CTRL_DEBOUNCE_EN
//     defined   : per-bit debounce FSM with a DB_CYCLES counter.
//     undefined : no counters or FSMs; the stable bit is s2 delayed one clock.
//
//   Ports
//     clk        single clock
//     reset_n    asynchronous active-low reset
//     address    register select:
//                  0 = data (RO), 1 = reserved (reads 0),
//                  2 = irqmask (RW), 3 = edgecapture (write 1 to clear)
//     chipselect qualifies writes
//     write_n    active-low write strobe
//     writedata  write data; only [7:0] is used
//     readdata   registered read data, one clock of latency
//     in_port    raw asynchronous switch inputs
//     irq        OR of (edgecapture & irqmask)
// -----------------------------------------------------------------------------

// Per-bit debouncer. Produces the stable bit and a one-cycle toggle flag that
// is high in the cycle whose clock edge flips the stable bit.
module lab61soc_switch_db #(
   parameter int unsigned DB_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sync_in,
   output logic stable,
   output logic toggle
);

`ifdef SWITCH_CTRL_DEBOUNCE_EN
   typedef enum logic {ST_STABLE, ST_COUNT} state_t;

   // Counter value on the DB_CYCLES-th consecutive differing edge.
   localparam logic [15:0] CNT_LAST = 16'(DB_CYCLES - 1);

   state_t      state, state_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic        stable_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_STABLE;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         stable <= stable_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      stable_nxt = stable;
      case (state)
         ST_STABLE: begin
            if (sync_in != stable) begin
               // The first differing edge already counts as edge number 1.
               if (CNT_LAST == 16'd0) begin
                  stable_nxt = ~stable;
               end else begin
                  state_nxt = ST_COUNT;
                  cnt_nxt   = 16'd1;
               end
            end
         end
         ST_COUNT: begin
            if (sync_in == stable) begin
               // Glitch: the input went back before the count completed.
               state_nxt = ST_STABLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               stable_nxt = ~stable;
               state_nxt  = ST_STABLE;
               cnt_nxt    = '0;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         default: begin
            state_nxt = ST_STABLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign toggle = stable_nxt ^ stable;
`else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) stable <= 1'b0;
      else          stable <= sync_in;
   end

   assign toggle = sync_in ^ stable;
`endif

endmodule

module lab61soc_switch_ctrl #(
   parameter int unsigned DB_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [7:0]  in_port,
   output logic        irq
);

   localparam int NUM_LANES = 8;

   logic [NUM_LANES-1:0] s1, s2;
   logic [NUM_LANES-1:0] stable, toggle;
   logic [NUM_LANES-1:0] irqmask, edgecap;
   logic [NUM_LANES-1:0] rd_mux, clr;
   logic                 wr_en;

   // Upper write data bits have no destination.
   logic unused_wd;
   assign unused_wd = ^writedata[31:8];

   // Two-flop synchronizer ahead of everything else.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= in_port;
         s2 <= s1;
      end
   end

   lab61soc_switch_db #(.DB_CYCLES(DB_CYCLES)) u_db [NUM_LANES-1:0] (
      .clk     (clk),
      .reset_n (reset_n),
      .sync_in (s2),
      .stable  (stable),
      .toggle  (toggle)
   );

   assign wr_en = chipselect & ~write_n;
   assign clr   = (wr_en && address == 2'd3) ? writedata[NUM_LANES-1:0] : '0;

   // Set is OR-ed after the clear so a toggle in the same cycle wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask <= '0;
         edgecap <= '0;
      end else begin
         if (wr_en && address == 2'd2) irqmask <= writedata[NUM_LANES-1:0];
         edgecap <= (edgecap & ~clr) | toggle;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         2'd0:    rd_mux = stable;
         2'd2:    rd_mux = irqmask;
         2'd3:    rd_mux = edgecap;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= {24'd0, rd_mux};
   end

   assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_lab61soc_switch_ctrl.sv
module tb_lab61soc_switch_ctrl;

   localparam int DB = 4;
`ifdef SWITCH_CTRL_DEBOUNCE_EN
   localparam int DB_EFF = DB;
`else
   localparam int DB_EFF = 1;
`endif
   // Clocks from in_port change to the stable bit flipping.
   localparam int LAT = 2 + DB_EFF;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  in_port;
   logic        irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lab61soc_switch_ctrl #(.DB_CYCLES(DB)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   // Reference model: the stable bit follows the synchronized input once it has
   // disagreed for DB_EFF clocks in a row.
   logic [7:0]  m_s1, m_s2, m_stab, m_mask, m_ec, m_tog;
   logic [31:0] m_rd;
   int          m_run [8];

   always_comb begin
      m_tog = '0;
      for (int i = 0; i < 8; i++)
         m_tog[i] = (m_s2[i] != m_stab[i]) && (m_run[i] + 1 >= DB_EFF);
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_s1 <= '0; m_s2 <= '0; m_stab <= '0; m_mask <= '0; m_ec <= '0; m_rd <= '0;
         for (int i = 0; i < 8; i++) m_run[i] <= 0;
      end else begin
         m_s1   <= in_port;
         m_s2   <= m_s1;
         m_stab <= m_stab ^ m_tog;
         for (int i = 0; i < 8; i++)
            m_run[i] <= (m_s2[i] != m_stab[i] && !m_tog[i]) ? m_run[i] + 1 : 0;
         if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[7:0];
         m_ec <= (m_ec & ~((chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00)) | m_tog;
         case (address)
            2'd0: m_rd <= {24'd0, m_stab};
            2'd2: m_rd <= {24'd0, m_mask};
            2'd3: m_rd <= {24'd0, m_ec};
            default: m_rd <= '0;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model_readdata", readdata, m_rd);
      chk("model_irq", {31'd0, irq}, {31'd0, |(m_ec & m_mask)});
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
      cyc(1);
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
      address = a;
      cyc(1);
      chk(name, readdata, exp);
   endtask

   initial begin
      reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = '0;
      cyc(3);
      chk("reset_readdata", readdata, 32'h0);
      chk("reset_irq", {31'd0, irq}, 32'h0);
      reset_n = 1'b1;
      cyc(2);

      // Short pulse on bit0: rejected when debouncing, passed otherwise.
      in_port = 8'h01;
      cyc(3);
      in_port = 8'h00;
      cyc(10);
      chk("glitch_data", readdata, 32'h0);
      rd_chk(2'd3, (DB_EFF > 3) ? 32'h0 : 32'h1, "glitch_ec");
      wr_reg(2'd3, 32'hFF);
      cyc(2);

      // Clean 0->1 on bit0, exact latency.
      address = 2'd0;
      cyc(1);
      in_port = 8'h01;
      cyc(LAT);
      chk("latency_before", readdata, 32'h0);
      cyc(1);
      chk("latency_data", readdata, 32'h1);
      rd_chk(2'd3, 32'h1, "latency_ec");
      wr_reg(2'd3, 32'h1);
      cyc(1);
      chk("w1c_ec", readdata, 32'h0);

      // Interrupt masking.
      wr_reg(2'd2, 32'h1);
      in_port = 8'h00;
      cyc(LAT + 1);
      chk("irq_set", {31'd0, irq}, 32'h1);
      wr_reg(2'd3, 32'h1);
      chk("irq_clear", {31'd0, irq}, 32'h0);
      wr_reg(2'd2, 32'h0);
      in_port = 8'h01;
      cyc(LAT + 1);
      chk("irq_masked", {31'd0, irq}, 32'h0);
      rd_chk(2'd3, 32'h1, "ec_masked");

      // Clear bit2 on the very edge bit2 becomes stable: set must win.
      wr_reg(2'd3, 32'hFF);
      in_port = 8'h05;
      cyc(LAT - 1);
      wr_reg(2'd3, 32'h4);
      cyc(1);
      chk("set_wins", readdata, 32'h4);

      // Register map details.
      wr_reg(2'd2, 32'hABCD_125A);
      rd_chk(2'd2, 32'h5A, "mask_readback");
      wr_reg(2'd1, 32'hFFFF_FFFF);
      rd_chk(2'd1, 32'h0, "addr1_zero");
      address = 2'd2; write_n = 1'b0; writedata = 32'hFF;
      cyc(1);
      write_n = 1'b1;
      rd_chk(2'd2, 32'h5A, "cs_gate");

      // Inputs high through reset.
      in_port = 8'hFF;
      reset_n = 1'b0;
      cyc(1);
      chk("rst2_readdata", readdata, 32'h0);
      chk("rst2_irq", {31'd0, irq}, 32'h0);
      address = 2'd0;
      reset_n = 1'b1;
      cyc(LAT);
      chk("rst_high_before", readdata, 32'h0);
      cyc(1);
      chk("rst_high_data", readdata, 32'hFF);
      rd_chk(2'd3, 32'hFF, "rst_high_ec");
      rd_chk(2'd2, 32'h0, "rst_mask");

      // Reset in the middle of a count.
      wr_reg(2'd3, 32'hFF);
      in_port = 8'h00;
      cyc(4);
      reset_n = 1'b0;
      cyc(1);
      chk("midcount_rst", readdata, 32'h0);
      reset_n = 1'b1;
      address = 2'd3;
      cyc(LAT + 3);
      chk("midcount_ec", readdata, 32'h0);
      rd_chk(2'd0, 32'h0, "midcount_data");

      // Several bits at once.
      in_port = 8'hA5;
      cyc(LAT);
      chk("multi_before", readdata, 32'h0);
      cyc(1);
      chk("multi_data", readdata, 32'hA5);
      rd_chk(2'd3, 32'hA5, "multi_ec");

      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
